// File: rtl/ksa_mp_seq.sv
// Multi-precision add/subtract sequencer.
// Streams a WORDS x SIZE-bit operand pair through one SIZE-bit Kogge-Stone
// adder, least-significant word first, and chains each word's carry-out
// into the next word's carry-in.
//
//   state | meaning
//   IDLE  | waiting for a request, start_ready_o high
//   RUN   | one word per cycle through the adder, k_q = 0..WORDS-1
//   DONE  | result held stable, res_valid_o high until consumed

// Kogge-Stone prefix adder: S = A + B + Cin, Co = carry out of the MSB.
module KSA_Nbit #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            Cin,
    output logic [SIZE-1:0] S,
    output logic            Co
);
    localparam int LV = $clog2(SIZE);

    logic [SIZE-1:0] hp;
    logic [SIZE-1:0] g;
    logic [SIZE-1:0] p;
    logic [SIZE-1:0] g_n;
    logic [SIZE-1:0] p_n;
    logic [SIZE-1:0] carry;

    // Log-depth prefix tree; Cin is folded into bit 0's generate so every
    // final group generate is the carry into the next bit.
    always_comb begin
        hp    = A ^ B;
        g     = A & B;
        g[0]  = g[0] | (hp[0] & Cin);
        p     = hp;
        g_n   = '0;
        p_n   = '0;
        for (int l = 0; l < LV; l++) begin
            g_n = g;
            p_n = p;
            for (int i = 0; i < SIZE; i++) begin
                if (i >= (1 << l)) begin
                    g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p_n[i] = p[i] & p[i - (1 << l)];
                end
            end
            g = g_n;
            p = p_n;
        end
        carry = {g[SIZE-2:0], Cin};
        S     = hp ^ carry;
        Co    = g[SIZE-1];
    end
endmodule

module ksa_mp_seq #(
    parameter int SIZE  = 32,
    parameter int WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic                  op_sub_i,
    input  logic [WORDS*SIZE-1:0] a_i,
    input  logic [WORDS*SIZE-1:0] b_i,
    input  logic                  cin_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [WORDS*SIZE-1:0] sum_o,
    output logic                  cout_o,
    output logic                  ovf_o,
    output logic                  busy_o
);
    localparam int W  = WORDS * SIZE;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            op_sub_q, op_sub_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [KW-1:0]   k_q, k_d;

    logic [SIZE-1:0] add_a;
    logic [SIZE-1:0] add_b;
    logic [SIZE-1:0] add_s;
    logic            add_co;
    logic            last_word;

    // Current word's operands; B is inverted in sub mode so A - B = A + ~B + 1.
    assign add_a     = a_q[k_q*SIZE +: SIZE];
    assign add_b     = b_q[k_q*SIZE +: SIZE] ^ {SIZE{op_sub_q}};
    assign last_word = (k_q == KW'(WORDS - 1));

    KSA_Nbit #(.SIZE(SIZE)) u_ksa (
        .A   (add_a),
        .B   (add_b),
        .Cin (carry_q),
        .S   (add_s),
        .Co  (add_co)
    );

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            op_sub_q <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            op_sub_q <= op_sub_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            k_q      <= k_d;
        end
    end

    // Next-state, word sequencing and handshake outputs.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        sum_d         = sum_q;
        op_sub_d      = op_sub_q;
        carry_d       = carry_q;
        cout_d        = cout_q;
        ovf_d         = ovf_q;
        k_d           = k_q;
        start_ready_o = 1'b0;
        res_valid_o   = 1'b0;
        busy_o        = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                start_ready_o = 1'b1;
                busy_o        = 1'b0;
                if (start_valid_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    op_sub_d = op_sub_i;
                    // In sub mode the +1 of two's complement and the borrow-in share this bit.
                    carry_d  = cin_i ^ op_sub_i;
                    k_d      = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[k_q*SIZE +: SIZE] = add_s;
                carry_d                 = add_co;
                if (last_word) begin
                    cout_d  = add_co;
                    ovf_d   = (add_a[SIZE-1] == add_b[SIZE-1]) &&
                              (add_s[SIZE-1] != add_a[SIZE-1]);
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
endmodule

// File: doc/ksa_mp_seq.md
# ksa_mp_seq

Multi-precision add/subtract sequencer built around one `KSA_Nbit` instance of width SIZE. It accepts a WORDS×SIZE-bit operand pair through a valid/ready handshake and feeds the adder one word per cycle, least-significant word first, carrying Co into the next word's Cin. It returns the full-width result, carry-out and signed overflow through a second valid/ready handshake. It is the block that lets datapaths needing 64- or 128-bit add/sub share a single 32-bit prefix adder.

## Interface
- SIZE, 32: adder word width passed to `KSA_Nbit`; legal range 17..32.
- WORDS, 4: number of words per operation; legal range 1..16.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request present.
- start_ready  out  1  request accepted when high with start_valid.
- op_sub  in  1  0 = A + B + cin; 1 = A − B − cin (cin acts as borrow-in).
- a  in  WORDS*SIZE  operand A, unsigned or two's complement.
- b  in  WORDS*SIZE  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- sum  out  WORDS*SIZE  result.
- cout  out  1  final carry; in sub mode 1 = no borrow (A ≥ B + cin, unsigned).
- ovf  out  1  two's-complement overflow of the full-width operation.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: start_ready = 1.
  - RUN: word index k counts 0..WORDS−1.
  - DONE: res_valid = 1.
- Accept: on start_valid && start_ready, register a, b and op_sub. Initialise carry_reg = cin XOR op_sub and k = 0. Go to RUN.
- In each RUN cycle, the adder inputs are:
  - A = a_reg word k.
  - B = b_reg word k XOR {SIZE{op_sub_reg}}.
  - Cin = carry_reg.
- On each RUN clock edge:
  - Sum word k is written into sum_reg word k.
  - carry_reg ← Co.
  - k increments.
- When k = WORDS−1:
  - cout ← Co.
  - ovf ← (A_msb == B'_msb) && (S_msb != A_msb), using the inverted B word in sub mode.
  - Go to DONE.
- DONE: sum, cout and ovf stay stable while res_valid is high. On res_valid && res_ready, go to IDLE.
- Input changes while not in IDLE are ignored, because operands are registered at accept.
- start_valid high outside IDLE is not accepted; start_ready stays 0.
- Width rules:
  - Word k occupies bits [k*SIZE +: SIZE].
  - All arithmetic is modulo 2^(WORDS*SIZE).
  - No sign extension.
- Reset values, asserted asynchronously and applying mid-operation as well:
  - State = IDLE, start_ready = 1, res_valid = 0, busy = 0.
  - sum = 0, cout = 0, ovf = 0, carry_reg = 0, k = 0.
  - Any in-flight operation is discarded.

## Timing
- Accept edge T0; RUN edges T0+1 .. T0+WORDS.
- res_valid is high from after edge T0+WORDS. Latency is WORDS cycles from accept to result.
- A result consumed at edge T1 returns start_ready high after T1. The next accept is possible at T1+1, so minimum throughput is one operation per WORDS+2 cycles.
- WORDS = 1: a single RUN cycle; res_valid is high after T0+1.
- The adder path is combinational within one cycle: register to `KSA_Nbit` to register. No combinational path from start_valid to start_ready, or from res_ready to res_valid.
- rst_n deassertion is synchronised by the integrating design. The block requires only that rst_n rise away from a clk edge.

## Test plan
All cases use WORDS = 4, SIZE = 32.

1. Cross-word carry: add, a = 0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b = 1, cin = 0 → sum = 0x0000_0001_0000_0000_0000_0000_0000_0000, cout = 0, ovf = 0, res_valid exactly 4 cycles after accept.
2. Full wrap: add, a = all ones, b = 0, cin = 1 → sum = 0, cout = 1, ovf = 0.
3. Subtract with borrow: sub, a = 0, b = 1, cin = 0 → sum = all ones, cout = 0, ovf = 0. Then sub with a = 5, b = 3, cin = 1 → sum = 1, cout = 1.
4. Signed overflow:
   - Add, a = 0x7FFF…FFFF, b = 1 → sum = 0x8000…0000, ovf = 1, cout = 0.
   - Sub, a = 0x8000…0000, b = 1 → ovf = 1.
5. Backpressure: hold res_ready = 0 for 6 cycles after res_valid → sum, cout and ovf are stable. start_ready stays 0 and start_valid pulses with new operands are not accepted. Releasing res_ready returns the block to IDLE on the next edge.
6. Reset mid-RUN: assert rst_n low while k = 2 → outputs take reset values immediately, with no clock edge needed. After release, case 1 repeats with the correct result.
